// File: rtl/alu4_acc_ctrl.sv
// alu4_acc_ctrl: accumulator sequencer wrapped around the 4-bit ALU.
// Drives the ALU operands and opcode, waits SETTLE cycles for the result,
// then captures the result into the accumulator and the n/z/c/v flags.
// Optional feature: define ALU4_ACC_CNT_EN to add the op_cnt output, an
// 8-bit count of completed EXEC commands that is cleared by CLRF.
module alu4_acc_ctrl #(
    parameter logic [3:0] ACC_INIT = 4'h0,
    parameter int         SETTLE   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_kind,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_v,
    output logic [3:0] acc,
    output logic [3:0] flags,
`ifdef ALU4_ACC_CNT_EN
    output logic [7:0] op_cnt,
`endif
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] KIND_EXEC = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_CLRF = 2'b10;

    // Settle count is held in 4 bits; legal SETTLE values are 1..15.
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_r;
    logic [3:0] cnt_r;
    logic [3:0] acc_r;
    logic [3:0] flags_r;
    logic [3:0] alu_b_r;
    logic [2:0] alu_op_r;
    logic       done_r;
    logic       ready_r;
    logic       accept_s;
`ifdef ALU4_ACC_CNT_EN
    logic [7:0] op_cnt_r;
`endif

    assign accept_s = cmd_valid & ready_r;

    // Command sequencer: accept, settle wait, capture and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            acc_r    <= ACC_INIT;
            flags_r  <= 4'd0;
            alu_b_r  <= 4'd0;
            alu_op_r <= 3'd0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
`ifdef ALU4_ACC_CNT_EN
            op_cnt_r <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ready_r <= 1'b0;
                        case (cmd_kind)
                            KIND_EXEC: begin
                                alu_b_r  <= cmd_data;
                                alu_op_r <= cmd_op;
                                cnt_r    <= SETTLE_C;
                                state_r  <= ST_WAIT;
                            end
                            KIND_LOAD: begin
                                acc_r   <= cmd_data;
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            KIND_CLRF: begin
                                flags_r <= 4'd0;
`ifdef ALU4_ACC_CNT_EN
                                op_cnt_r <= 8'd0;
`endif
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            default: begin
                                // NOP: only the done handshake.
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                        endcase
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd1) begin
                        acc_r   <= alu_result;
                        flags_r <= {alu_n, alu_z, alu_c, alu_v};
`ifdef ALU4_ACC_CNT_EN
                        op_cnt_r <= op_cnt_r + 8'd1;
`endif
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = ~ready_r;
    assign done      = done_r;
    assign acc       = acc_r;
    assign alu_a     = acc_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign flags     = flags_r;
`ifdef ALU4_ACC_CNT_EN
    assign op_cnt    = op_cnt_r;
`endif

endmodule

// File: doc/alu4_acc_ctrl.md
# alu4_acc_ctrl

Accumulator sequencer that sits on both sides of the 4-bit ALU: it drives the ALU's `a`, `b` and `op` inputs and captures its `result` and c/n/z/v flags back into an accumulator and a flag register. Commands arrive over a valid/ready handshake. Results chain naturally: the accumulator is always ALU operand `a`, so successive EXEC commands operate on the previous result. This is the first sequential stage around the ALU and is the block later datapath stages read the accumulator and flags from.

## Interface
Parameters:
- `ACC_INIT`, default `4'h0`: accumulator value after reset.
- `SETTLE`, default `1`, legal range 1..15: number of cycles the ALU inputs are held before result capture.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset. Asynchronous, active-high.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  the block accepts a command this cycle.
- `cmd_kind`  in  2  command kind: 00 EXEC, 01 LOAD, 10 CLRF, 11 NOP.
- `cmd_op`  in  3  ALU opcode; used by EXEC only.
- `cmd_data`  in  4  operand `b` for EXEC, or the load value for LOAD.
- `alu_a`  out  4  to ALU input `a`; always equals `acc`.
- `alu_b`  out  4  to ALU input `b`; registered.
- `alu_op`  out  3  to ALU input `op`; registered.
- `alu_result`  in  4  from ALU `result`.
- `alu_c`, `alu_n`, `alu_z`, `alu_v`  in  1 each  from ALU flags.
- `acc`  out  4  accumulator.
- `flags`  out  4  registered flags, ordered {n, z, c, v}.
- `done`  out  1  one-cycle pulse when a command completes.
- `busy`  out  1  equals `~cmd_ready`.

## Operation
- FSM states: IDLE, WAIT, DONE. `cmd_ready` is 1 only in IDLE.
- Accept: a command is accepted on a rising edge where `cmd_valid & cmd_ready` is 1.
- EXEC:
  - On the accept edge, `alu_b` <= `cmd_data`, `alu_op` <= `cmd_op`, the settle counter is loaded, and the state goes to WAIT.
  - WAIT lasts exactly `SETTLE` cycles.
  - On the edge that ends WAIT, `acc` <= `alu_result` and `flags` <= {`alu_n`, `alu_z`, `alu_c`, `alu_v`}, and the state goes to DONE.
- LOAD: on the accept edge, `acc` <= `cmd_data`; flags are unchanged; go to DONE.
- CLRF: on the accept edge, `flags` <= 0; `acc` is unchanged; go to DONE.
- NOP: no state change other than going to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Commands presented outside IDLE are not accepted. The upstream stage must hold `cmd_*` stable until it sees `cmd_ready`.
- Widths: `acc` and `alu_b` are 4 bits, so no extension or truncation is performed. The ALU result is stored verbatim.
- Flags are never modified by LOAD or NOP.

## Timing
- Reset values (asynchronous, applied immediately):
  - state IDLE, `acc` = `ACC_INIT`, `flags` = 0, `alu_b` = 0, `alu_op` = 0;
  - `done` = 0, `cmd_ready` = 1, `busy` = 0.
- EXEC latency: accepted at edge E0; ALU inputs are valid from E0 onward; capture at edge E(`SETTLE`); `done` is high in the cycle after E(`SETTLE`). The next accept is possible at the edge E(`SETTLE`+2). Total occupancy is `SETTLE`+2 cycles.
- LOAD/CLRF/NOP latency: update at E0, `done` high in the cycle after E0, next accept at E2.
- Back-to-back EXEC: the second EXEC uses the new `acc` as `alu_a`. No forwarding is needed because `acc` is already registered before the second accept.
- Reset asserted mid-WAIT or in DONE: the pending command is dropped, no capture occurs, and `done` is not pulsed.
- `cmd_valid` deasserted in IDLE: the block holds all state; `done` stays 0.

## Configuration
- Macro `ALU4_ACC_CNT_EN`.
- Defined:
  - adds output `op_cnt` (8 bits), the count of completed EXEC commands;
  - increments on the capture edge and wraps from 255 to 0;
  - resets to 0 and is also cleared by CLRF.
- Undefined: the `op_cnt` port and its counter are absent; all other behaviour is identical.

## Test plan
The bench uses an ALU stub with a programmable result/flags, plus the real `alu4`.
- Reset, then idle: `acc` = 0, `flags` = 0, `cmd_ready` = 1, `done` = 0; holds for 5 cycles with `cmd_valid` = 0.
- LOAD 4'b1011:
  - `acc` = 4'b1011 after E0, `done` pulses 1 cycle, `flags` unchanged;
  - `alu_a` = 4'b1011 from that point.
- EXEC with `SETTLE` = 1, op 3'b000, data 4'b0110, stub result 4'b1111 with n=1, v=1:
  - `alu_b` = 4'b0110 and `alu_op` = 0 at E0;
  - `acc` = 4'b1111 and `flags` = 4'b1001 at E1;
  - `done` high in cycle 2;
  - `cmd_ready` low for 2 cycles.
- Two chained EXECs with stub results 4'b0000 (z=1) then 4'b0001: the second EXEC shows `alu_a` = 4'b0000 during WAIT; the final `acc` = 4'b0001 and `flags` = 4'b0000.
- CLRF after a nonzero capture: `flags` = 0 and `acc` unchanged. With `ALU4_ACC_CNT_EN` defined, 256 EXECs leave `op_cnt` = 0 and 257 EXECs leave `op_cnt` = 1.
- Reset asserted during WAIT with `SETTLE` = 3: immediately `acc` = `ACC_INIT`, `cmd_ready` = 1, and no `done` pulse follows.
